// File: rtl/skew_feeder_pkg.sv
// skew_feeder_pkg: default geometry (W, N, K_MAX) and FSM state encoding shared by the feeder and the array top
package skew_feeder_pkg;
  localparam int W_DEF = 16;
  localparam int N_DEF = 4;
  localparam int K_MAX_DEF = 8;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/skew_feeder_if.sv
// skew_feeder_if: job control (i_start/i_k_len/i_mode), load handshake (i_valid/o_ready, i_a_vec/i_b_vec) and skewed array outputs (o_A/o_B/o_en/o_mode/o_done/o_err)
interface skew_feeder_if import skew_feeder_pkg::*; #(
  parameter int W = W_DEF,
  parameter int N = N_DEF,
  parameter int K_MAX = K_MAX_DEF
) ();
  logic i_start;
  logic [$clog2(K_MAX+1)-1:0] i_k_len;
  logic i_mode;
  logic i_valid;
  logic o_ready;
  logic [N*W-1:0] i_a_vec;
  logic [N*W-1:0] i_b_vec;
  logic [N*W-1:0] o_A;
  logic [N*W-1:0] o_B;
  logic o_en;
  logic o_mode;
  logic o_done;
  logic o_err;
  modport master (
    output i_start, i_k_len, i_mode, i_valid, i_a_vec, i_b_vec,
    input o_ready, o_A, o_B, o_en, o_mode, o_done, o_err
  );
  modport slave (
    input i_start, i_k_len, i_mode, i_valid, i_a_vec, i_b_vec,
    output o_ready, o_A, o_B, o_en, o_mode, o_done, o_err
  );
endinterface

// File: rtl/skew_feeder_delay2.sv
// skew_feeder_delay2: DEPTH-stage registered delay line (i_clk, i_rst clears, d in, q out)
module skew_feeder_delay2 #(
  parameter int W = 16,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_rst) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: buffers K beats of A columns / B rows, then streams them row-skewed into an N x N systolic array (i_clk, i_rst, bus = skew_feeder_if.slave)
module skew_feeder import skew_feeder_pkg::*; #(
  parameter int W = W_DEF,
  parameter int N = N_DEF,
  parameter int K_MAX = K_MAX_DEF
) (
  input logic i_clk,
  input logic i_rst,
  skew_feeder_if.slave bus
);
  localparam int KL = $clog2(K_MAX + 1);
  localparam int CW = $clog2(K_MAX + N + 1);
  localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d, k_ext;
  logic [KL-1:0] k_q;
  logic mode_q, err_q, start_ok, en, rd;
  logic [N*W-1:0] a_buf [K_MAX];
  logic [N*W-1:0] b_buf [K_MAX];
  logic [N*W-1:0] a_src, b_src, a_sk, b_sk;
  assign k_ext = CW'(k_q);
  assign start_ok = bus.i_start && bus.i_k_len != '0 && bus.i_k_len <= KL'(K_MAX);
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      S_IDLE: begin
        state_d = start_ok ? S_LOAD : S_IDLE;
        cnt_d = '0;
      end
      S_LOAD: if (bus.i_valid) begin
        state_d = (cnt == k_ext - 1'b1) ? S_STREAM : S_LOAD;
        cnt_d = (cnt == k_ext - 1'b1) ? '0 : cnt + 1'b1;
      end
      S_STREAM: begin
        state_d = (cnt == k_ext + CW'(N - 2)) ? S_DRAIN : S_STREAM;
        cnt_d = (cnt == k_ext + CW'(N - 2)) ? '0 : cnt + 1'b1;
      end
      S_DRAIN: begin
        state_d = (cnt == CW'(N)) ? S_DONE : S_DRAIN;
        cnt_d = (cnt == CW'(N)) ? '0 : cnt + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      k_q <= '0;
      mode_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      err_q <= state == S_IDLE && bus.i_start && !start_ok;
      if (state == S_IDLE && start_ok) begin
        k_q <= bus.i_k_len;
        mode_q <= bus.i_mode;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (state == S_LOAD && bus.i_valid) begin
      a_buf[cnt[AW-1:0]] <= bus.i_a_vec;
      b_buf[cnt[AW-1:0]] <= bus.i_b_vec;
    end
  end
  // Unskewed source is column s of the buffer during the first K stream cycles and zero otherwise,
  // so delay lines fill with zeros before and after the job and lane r sees A[s-r] after r cycles.
  assign rd = state == S_STREAM && cnt < k_ext;
  assign a_src = rd ? a_buf[cnt[AW-1:0]] : '0;
  assign b_src = rd ? b_buf[cnt[AW-1:0]] : '0;
  assign a_sk[W-1:0] = a_src[W-1:0];
  assign b_sk[W-1:0] = b_src[W-1:0];
  for (genvar r = 1; r < N; r++) begin : g_lane
    skew_feeder_delay2 #(.W(W), .DEPTH(r)) u_a (.i_clk(i_clk), .i_rst(i_rst), .d(a_src[r*W +: W]), .q(a_sk[r*W +: W]));
    skew_feeder_delay2 #(.W(W), .DEPTH(r)) u_b (.i_clk(i_clk), .i_rst(i_rst), .d(b_src[r*W +: W]), .q(b_sk[r*W +: W]));
  end
  assign en = state inside {S_STREAM, S_DRAIN, S_DONE};
  assign bus.o_A = a_sk;
  assign bus.o_B = b_sk;
  assign bus.o_en = en;
  assign bus.o_mode = en & mode_q;
  assign bus.o_ready = state == S_LOAD;
  assign bus.o_done = state == S_DONE;
  assign bus.o_err = err_q;
endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: table-driven and randomized job checks of skew_feeder against a schedule model
module tb_skew_feeder;
  localparam int W = 16, N = 4, K_MAX = 8;
  typedef struct {
    int k;
    bit mode;
    int pct;
    int gap;
    bit fixed;
    int rst_s;
    int spur_s;
  } job_t;
  logic clk = 1'b0, rst = 1'b1;
  int errors = 0, checks = 0;
  job_t tbl[$];
  skew_feeder_if #(.W(W), .N(N), .K_MAX(K_MAX)) sf ();
  skew_feeder #(.W(W), .N(N), .K_MAX(K_MAX)) dut (.i_clk(clk), .i_rst(rst), .bus(sf));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] exp_vec(input logic [63:0] m [K_MAX], input int s, input int k);
    logic [63:0] v = '0;
    for (int r = 0; r < N; r++)
      if (s < k + N - 1 && s - r >= 0 && s - r < k) v[r*W +: W] = m[s-r][r*W +: W];
    return v;
  endfunction
  task automatic chk_quiet(input string nm);
    chk({nm, "_ready"}, sf.o_ready, 0);
    chk({nm, "_en"}, sf.o_en, 0);
    chk({nm, "_mode"}, sf.o_mode, 0);
    chk({nm, "_done"}, sf.o_done, 0);
    chk({nm, "_A"}, sf.o_A, 0);
    chk({nm, "_B"}, sf.o_B, 0);
  endtask
  task automatic run_job(input job_t j);
    logic [63:0] am [K_MAX];
    logic [63:0] bm [K_MAX];
    logic [63:0] a, b;
    int acc = 0, cyc = 0;
    bit v;
    bit bad = (j.k == 0 || j.k > K_MAX);
    repeat (j.gap) begin
      chk("gap_en", sf.o_en, 0);
      @(negedge clk);
    end
    chk_quiet("idle");
    sf.i_start = 1'b1;
    sf.i_k_len = 4'(j.k);
    sf.i_mode = j.mode;
    @(negedge clk);
    sf.i_start = 1'b0;
    chk("err_pulse", sf.o_err, 64'(bad));
    chk("ready_after_start", sf.o_ready, 64'(!bad));
    if (bad) begin
      @(negedge clk);
      chk("err_once", sf.o_err, 0);
      chk("ready_idle", sf.o_ready, 0);
      return;
    end
    while (acc < j.k && cyc < 200) begin
      v = j.pct < 0 ? (cyc % 2 == 0) : ($urandom_range(99) < j.pct);
      chk("load_ready", sf.o_ready, 1);
      chk("load_en", sf.o_en, 0);
      a = j.fixed ? 64'h0004_0003_0002_0001 : {$urandom, $urandom};
      b = j.fixed ? 64'h0004_0003_0002_0001 : {$urandom, $urandom};
      sf.i_valid = v;
      sf.i_a_vec = a;
      sf.i_b_vec = b;
      if (v) begin
        am[acc] = a;
        bm[acc] = b;
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    sf.i_valid = 1'b0;
    if (acc < j.k) begin
      chk("load_budget", 64'(acc), 64'(j.k));
      return;
    end
    for (int s = 0; s <= j.k + 2 * N; s++) begin
      chk("stream_ready", sf.o_ready, 0);
      chk("stream_en", sf.o_en, 1);
      chk("stream_mode", sf.o_mode, 64'(j.mode));
      chk("stream_done", sf.o_done, 64'(s == j.k + 2 * N));
      chk("stream_err", sf.o_err, 0);
      chk("stream_A", sf.o_A, exp_vec(am, s, j.k));
      chk("stream_B", sf.o_B, exp_vec(bm, s, j.k));
      sf.i_start = (s == j.spur_s);
      sf.i_valid = (s == j.spur_s);
      sf.i_k_len = 4'd1;
      if (s == j.rst_s) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sf.i_start = 1'b0;
        sf.i_valid = 1'b0;
        chk_quiet("after_rst");
        chk("after_rst_err", sf.o_err, 0);
        return;
      end
      @(negedge clk);
    end
    sf.i_start = 1'b0;
    sf.i_valid = 1'b0;
    chk_quiet("post_done");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    job_t j;
    sf.i_start = 1'b0;
    sf.i_k_len = '0;
    sf.i_mode = 1'b0;
    sf.i_valid = 1'b0;
    sf.i_a_vec = '0;
    sf.i_b_vec = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_err", sf.o_err, 0);
    rst = 1'b0;
    @(negedge clk);
    tbl.push_back('{1, 1'b0, 100, 0, 1'b1, -1, -1});
    tbl.push_back('{0, 1'b0, 100, 1, 1'b0, -1, -1});
    tbl.push_back('{9, 1'b1, 100, 0, 1'b0, -1, -1});
    tbl.push_back('{8, 1'b1, 100, 0, 1'b0, -1, -1});
    tbl.push_back('{3, 1'b0, -1, 2, 1'b0, -1, -1});
    tbl.push_back('{5, 1'b1, 60, 0, 1'b0, -1, 1});
    tbl.push_back('{6, 1'b0, 100, 1, 1'b0, 3, -1});
    tbl.push_back('{2, 1'b1, 100, 0, 1'b0, -1, -1});
    tbl.push_back('{8, 1'b0, 100, 0, 1'b0, -1, -1});
    tbl.push_back('{4, 1'b1, 30, 0, 1'b0, -1, -1});
    tbl.push_back('{7, 1'b1, -1, 0, 1'b0, -1, 2});
    foreach (tbl[i]) run_job(tbl[i]);
    for (int i = 0; i < 30; i++) begin
      j.k = $urandom_range(0, 9);
      j.mode = 1'($urandom_range(0, 1));
      j.pct = $urandom_range(20, 100);
      j.gap = $urandom_range(0, 2);
      j.fixed = 1'b0;
      j.rst_s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : -1;
      j.spur_s = ($urandom_range(0, 3) == 0) ? 1 : -1;
      run_job(j);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
